cnn_ofm_reader: RTL and testbench

Reads the cnn output feature-map buffer after a layer completes and streams it out, one 32-bit IEEE-754 single-precision word per beat, over a valid/ready interface.
- Read order: map-major raster (m, then r, then c).
- Sits between the cnn output buffer (synchronous-read RAM, 1-cycle latency) and the host/DMA egress path.
- It is the reader counterpart to the cnn writing fm_o.

---
 rtl/cnn_pkg.sv | 27 ++
 rtl/cnn_skid_fifo.sv | 54 +++++
 rtl/cnn_ofm_reader.sv | 142 ++++++++++++++
 tb/tb_cnn_ofm_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the cnn feature-map datapath blocks.
// Sizing functions are evaluated at elaboration time from module parameters.
package cnn_pkg;

    typedef logic [31:0] fp32_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ofm_rd_state_e;

    function automatic int total_words(input int m, input int r, input int c);
        return m * r * c;
    endfunction

    // Widths are clamped to 1 so degenerate sizes still yield legal vectors.
    function automatic int addr_width(input int m, input int r, input int c);
        return (m * r * c > 1) ? $clog2(m * r * c) : 1;
    endfunction

    function automatic int map_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/cnn_skid_fifo.sv
// Two-entry FIFO with push/pop in the same cycle and full/empty/count status.
// Head word is presented combinationally from storage and holds until popped.
module cnn_skid_fifo #(
    parameter int WIDTH_p = 32,
    parameter int DEPTH_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [WIDTH_p-1:0] data_i,
    input  logic               pop_i,
    output logic [WIDTH_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [1:0]         count_o
);

    logic [WIDTH_p-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty_o = (count_o == 2'd0);
    assign full_o  = (count_o == 2'(DEPTH_p));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_o <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + 2'd1;
                2'b01:   count_o <= count_o - 2'd1;
                default: count_o <= count_o;
            endcase
        end
    end

    // NOTE: storage has no reset; contents are meaningless until count_o says otherwise.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_i)
        push_i |-> (!full_o || pop_i));

endmodule

// File: rtl/cnn_ofm_reader.sv
// Streams a finished output feature-map buffer out in map-major raster order.
// Reads are credit-limited so every returning word is guaranteed a FIFO slot.
module cnn_ofm_reader
    import cnn_pkg::*;
#(
    parameter  int M_p          = 4,
    parameter  int R_p          = 16,
    parameter  int C_p          = 16,
    parameter  int W_p          = 32,
    parameter  int FIFO_DEPTH_p = 2,
    localparam int AW           = addr_width(M_p, R_p, C_p),
    localparam int MW           = map_width(M_p)
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           start_i,
    output logic           rd_en_o,
    output logic [AW-1:0]  rd_addr_o,
    input  logic [W_p-1:0] rd_data_i,
    output logic [W_p-1:0] data_o,
    output logic [MW-1:0]  map_o,
    output logic           last_o,
    output logic           valid_o,
    input  logic           ready_i,
    output logic           busy_o,
    output logic           done_o
);

    localparam int            TOTAL     = total_words(M_p, R_p, C_p);
    localparam int            PIX       = R_p * C_p;
    localparam int            PW        = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int            PAY_W     = W_p + MW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);
    localparam logic [PW-1:0] LAST_PIX  = PW'(PIX - 1);

    ofm_rd_state_e state;
    ofm_rd_state_e state_next;

    logic [AW-1:0]    addr;
    logic [MW-1:0]    map_cnt;
    logic [PW-1:0]    pix_cnt;
    logic             inflight;
    logic [MW-1:0]    pend_map;
    logic             pend_last;
    logic             pop;
    logic             at_last;
    logic [2:0]       credit;
    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       fifo_count;
    logic [PAY_W-1:0] head;

    assign pop     = valid_o & ready_i;
    assign at_last = (addr == LAST_ADDR);
    assign credit  = {1'b0, fifo_count} + {2'b00, inflight};

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        rd_en_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_next = READ;
            end
            READ: begin
                // Words buffered or returning, minus the one leaving now, must stay below depth.
                rd_en_o = (credit < 3'(FIFO_DEPTH_p) + {2'b00, pop});
                if (rd_en_o && at_last) state_next = DRAIN;
            end
            DRAIN: begin
                // Finish as the last word leaves so done_o follows it by exactly one cycle.
                if (!inflight && (fifo_count == {1'b0, pop})) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= state_next;
    end

    // Address stops at the final word rather than wrapping; it clears on the way to IDLE.
    always_ff @(posedge clk_i) begin
        if (!reset_i || state == DONE) begin
            addr    <= '0;
            map_cnt <= '0;
            pix_cnt <= '0;
        end else if (rd_en_o && !at_last) begin
            addr <= addr + 1'b1;
            if (pix_cnt == LAST_PIX) begin
                pix_cnt <= '0;
                map_cnt <= map_cnt + 1'b1;
            end else begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

    // Side information travels with the read so it lines up with returning data.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            inflight  <= 1'b0;
            pend_map  <= '0;
            pend_last <= 1'b0;
        end else begin
            inflight <= rd_en_o;
            if (rd_en_o) begin
                pend_map  <= map_cnt;
                pend_last <= at_last;
            end
        end
    end

    cnn_skid_fifo #(
        .WIDTH_p (PAY_W),
        .DEPTH_p (FIFO_DEPTH_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (inflight),
        .data_i  ({pend_last, pend_map, rd_data_i}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rd_addr_o                 = addr;
    assign valid_o                   = !fifo_empty;
    assign {last_o, map_o, data_o}   = valid_o ? head : '0;
    assign busy_o                    = (state != IDLE);
    assign done_o                    = (state == DONE);

    a_slot_for_return: assert property (@(posedge clk_i) disable iff (!reset_i)
        inflight |-> (!fifo_full || pop));

endmodule

// File: tb/tb_cnn_ofm_reader.sv
// Scoreboard bench for cnn_ofm_reader: expected beats queued at start, popped by a monitor.
module tb_cnn_ofm_reader;
    import cnn_pkg::*;

    localparam int TOTAL = 1024;
    localparam int PIX   = 256;

    typedef struct {
        fp32_t data;
        int    map;
        bit    last;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        rd_en;
    logic [9:0]  rd_addr;
    fp32_t       rd_data;
    fp32_t       data;
    logic [1:0]  map;
    logic        last;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;

    logic        s_start;
    logic        s_rd_en;
    logic [1:0]  s_rd_addr;
    fp32_t       s_rd_data;
    fp32_t       s_data;
    logic [0:0]  s_map;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic        s_busy;
    logic        s_done;

    int   checks = 0;
    int   errors = 0;
    int   beats = 0;
    int   reads = 0;
    int   done_count = 0;
    exp_t exp_q[$];

    cnn_ofm_reader u_dut (
        .clk_i(clk), .reset_i(reset_n), .start_i(start),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .data_o(data), .map_o(map), .last_o(last), .valid_o(valid),
        .ready_i(ready), .busy_o(busy), .done_o(done)
    );

    cnn_ofm_reader #(.M_p(1), .R_p(2), .C_p(2)) u_small (
        .clk_i(clk), .reset_i(reset_n), .start_i(s_start),
        .rd_en_o(s_rd_en), .rd_addr_o(s_rd_addr), .rd_data_i(s_rd_data),
        .data_o(s_data), .map_o(s_map), .last_o(s_last), .valid_o(s_valid),
        .ready_i(s_ready), .busy_o(s_busy), .done_o(s_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Exact single-precision encoding of a small non-negative integer.
    function automatic fp32_t int_to_fp(input int n);
        int    e;
        fp32_t m;
        if (n == 0) return 32'h0;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        m = fp32_t'(n) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    // Output buffers preloaded with addr -> float(addr), one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en)   rd_data   <= int_to_fp(int'(rd_addr));
        if (s_rd_en) s_rd_data <= int_to_fp(int'(s_rd_addr));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: tracks buffered/in-flight words abstractly and scores every handshake.
    initial begin : monitor
        exp_t        e;
        int          occ;
        int          infl;
        bit          pop;
        bit          prev_stall;
        bit          last_hs;
        logic [34:0] prev_head;
        occ = 0; infl = 0; prev_stall = 0; last_hs = 0; prev_head = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                occ = 0; infl = 0; prev_stall = 0; last_hs = 0;
                continue;
            end
            pop = valid && ready;
            check("valid_vs_occupancy", valid, occ > 0);
            check("done_timing", done, last_hs);
            if (done) done_count++;
            if (rd_en) begin
                reads++;
                check("read_credit", (occ + infl - int'(pop)) < 2, 1);
            end
            if (prev_stall)
                check("head_stable", {valid, last, map, data}, {1'b1, prev_head});
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {last, map, data}, '0);
                    errors += (checks > 0 && {last, map, data} == '0) ? 1 : 0;
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat_%0d", beats), {last, map, data},
                          {e.last, 2'(e.map), e.data});
                end
                beats++;
            end
            last_hs    = pop && last;
            prev_stall = valid && !ready;
            prev_head  = {last, map, data};
            occ        = occ + infl - int'(pop);
            infl       = int'(rd_en);
        end
    end

    // mode 0: ready high, 1: random 30% ready, 2: ready held low 50 cycles,
    // 3: extra start mid-transfer and during DONE, 4: reset at beat 500.
    task automatic run(input int mode);
        bit pulsed;
        beats = 0; reads = 0; done_count = 0; pulsed = 0;
        for (int i = 0; i < TOTAL; i++)
            exp_q.push_back('{data: int_to_fp(i), map: i / PIX, last: (i == TOTAL - 1)});
        ready = (mode != 2);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("first_read", {rd_en, rd_addr}, {1'b1, 10'd0});
        check("valid_cycle_k1", valid, 0);
        @(posedge clk); #1 check("valid_cycle_k2", valid, 0);
        @(posedge clk); #1 check("valid_cycle_k3", valid, 1);
        if (mode == 2) begin
            repeat (50) @(posedge clk);
            #1;
            check("stall_reads", reads, 2);
            check("stall_valid_head", {valid, data}, {1'b1, 32'h0});
            ready = 1'b1;
        end
        for (int cyc = 0; cyc < 20000 && done_count == 0; cyc++) begin
            @(posedge clk); #1;
            if (mode == 1) ready = ($urandom_range(0, 99) < 30);
            if (mode == 3) begin
                start = (beats == 100 && !pulsed) || done;
                if (beats == 100) pulsed = 1;
            end
            if (mode == 4 && beats >= 500) begin
                reset_n = 1'b0;
                @(posedge clk); #1 reset_n = 1'b1;
                check("reset_outputs_zero",
                      {rd_en, rd_addr, data, map, last, valid, busy, done}, '0);
                exp_q.delete();
                @(posedge clk); #1 check("stale_read_dropped", valid, 0);
                return;
            end
        end
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_seen", done_count > 0, 1);
        check("beat_count", beats, TOTAL);
        check("single_done", done_count, 1);
        check("queue_drained", exp_q.size(), 0);
        check("idle_after", {busy, valid, rd_en}, 3'b000);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n;
        int sdone;
        reset_n = 1'b0; start = 1'b0; ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {rd_en, rd_addr, data, map, last, valid, busy, done}, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run(0);
        run(1);
        run(2);
        run(3);
        run(4);
        run(0);

        s_ready = 1'b1;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        n = 0; sdone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_valid && s_ready) begin
                check($sformatf("small_beat_%0d", n), {s_last, s_map, s_data},
                      {(n == 3), 1'b0, int_to_fp(n)});
                n++;
            end
            if (s_done) sdone++;
        end
        check("small_beat_count", n, 4);
        check("small_done_count", sdone, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
